fetch_stage: RTL
================

FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 The block SHALL have parameter RESET_PC, default 32'h0000_0000, meaning the first fetch address after reset.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-004 The block SHALL have port imem_req, output, 1 bit: instruction-memory read request.
REQ-005 The block SHALL have port imem_addr, output, 32 bits: word-aligned read address.
REQ-006 The block SHALL have port imem_ack, input, 1 bit: single-cycle pulse meaning imem_rdata is valid this cycle.
REQ-007 The block SHALL have port imem_rdata, input, 32 bits: instruction word.
REQ-008 The block SHALL have port redirect_valid, input, 1 bit: branch taken or flush request from execute.
REQ-009 The block SHALL have port redirect_pc, input, 32 bits: new fetch target.
REQ-010 The block SHALL have port id_ready, input, 1 bit: decode accepts id_instr this cycle.
REQ-011 The block SHALL have port id_valid, output, 1 bit: id_instr, id_pc and id_pcplus4 are valid.
REQ-012 The block SHALL have port id_instr, output, 32 bits: fetched instruction.
REQ-013 The block SHALL have port id_pc, output, 32 bits: address of id_instr.
REQ-014 The block SHALL have port id_pcplus4, output, 32 bits: id_pc + 4.
REQ-015 The block SHALL have port Op, output, 7 bits: id_instr[6:0], driving the main decoder opcode input.

Function
REQ-016 The block SHALL hold registers pc (next fetch address), fetch_addr (address of the outstanding request) and a 3-state FSM: FETCH, DISCARD, HOLD.
REQ-017 The block SHALL keep at most one memory request outstanding; imem_req high with imem_addr = fetch_addr held stable until imem_ack.
REQ-018 In FETCH, imem_req SHALL be 1 and id_valid SHALL be 0; on entry, fetch_addr <= pc.
REQ-019 In FETCH on imem_ack with redirect_valid=0: id_instr <= imem_rdata, id_pc <= fetch_addr, id_pcplus4 <= fetch_addr+4, pc <= fetch_addr+4, go HOLD.
REQ-020 In HOLD, id_valid SHALL be 1 and imem_req SHALL be 0; outputs SHALL hold stable while id_ready=0.
REQ-021 In HOLD with id_ready=1: go FETCH, so imem_req=1 with the new pc on the next cycle.
REQ-022 Latency SHALL be 1 cycle from imem_ack to id_valid=1; minimum throughput SHALL be one instruction per (memory latency + 1) cycles.
REQ-023 redirect_valid SHALL take priority over every other event; the target used SHALL be {redirect_pc[31:2],2'b00}.
REQ-024 Redirect in FETCH without imem_ack: pc <= target, go DISCARD, and imem_req/imem_addr SHALL stay unchanged.
REQ-025 In DISCARD, imem_req SHALL be 1 and id_valid SHALL be 0; on imem_ack, rdata SHALL be dropped and the state SHALL go to FETCH.
REQ-026 Redirect in DISCARD SHALL update pc to the newest target; last redirect wins.
REQ-027 Redirect in FETCH coincident with imem_ack: rdata dropped, pc <= target, go FETCH.
REQ-028 Redirect in HOLD, with or without id_ready: id_valid SHALL be 0 next cycle, pc <= target, go FETCH.
REQ-029 Address arithmetic SHALL be modulo 2^32: fetch_addr 32'hFFFF_FFFC SHALL give pc and id_pcplus4 = 32'h0000_0000.
REQ-030 imem_ack outside FETCH/DISCARD SHALL be ignored.

Reset
REQ-031 While rst=1: state=FETCH, pc=fetch_addr=RESET_PC, imem_req=0, id_valid=0, id_instr=32'h0000_0013 (NOP), id_pc=0, id_pcplus4=0, Op=7'b0010011.
REQ-032 On the first clk edge after rst falls, imem_req SHALL be 1 with imem_addr=RESET_PC.
REQ-033 Reset asserted mid-request SHALL abandon the request; a late imem_ack after reset SHALL be treated as the response to the new RESET_PC request only if it arrives after imem_req rises.

Verification
REQ-034 The bench SHALL cover: reset release, ack after 2 cycles with rdata=32'h00500093 -> id_valid=1, id_pc=0, id_pcplus4=4, Op=7'b0010011.
REQ-035 The bench SHALL cover: id_ready held 0 for 3 cycles in HOLD -> outputs stable and imem_req=0; id_ready=1 -> next cycle imem_addr=4.
REQ-036 The bench SHALL cover: redirect_pc=32'h0000_0103 while waiting for ack -> imem_addr stays at the old value until ack, data dropped, next request at 32'h0000_0100.
REQ-037 The bench SHALL cover: redirect in HOLD with id_ready=1 -> id_valid=0 next cycle, next imem_addr=target.
REQ-038 The bench SHALL cover: two redirects during DISCARD to 32'h40 then 32'h80 -> next request at 32'h80.
REQ-039 The bench SHALL cover: fetch at 32'hFFFF_FFFC -> id_pcplus4=0 and next imem_addr=0.

Source files
------------

// File: rtl/fetch_stage.sv
// Instruction fetch stage: keeps one imem read outstanding, handles redirects/flushes,
// and hands each fetched word to decode through a registered valid/ready slot.
module fetch_stage #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   input  logic        id_ready,
   output logic        id_valid,
   output logic [31:0] id_instr,
   output logic [31:0] id_pc,
   output logic [31:0] id_pcplus4,
   output logic [6:0]  Op
);

   localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

   typedef enum logic [1:0] {
      S_FETCH   = 2'd0,
      S_DISCARD = 2'd1,
      S_HOLD    = 2'd2
   } state_t;

   state_t      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] fetch_addr_q, fetch_addr_d;
   logic [31:0] id_instr_q, id_instr_d;
   logic [31:0] id_pc_q, id_pc_d;
   logic [31:0] id_pcplus4_q, id_pcplus4_d;
   logic        imem_req_q, imem_req_d;
   logic        id_valid_q, id_valid_d;
   logic        ack_s;
   logic [31:0] target_s;
   logic [31:0] seq_pc_s;

   // An ack only counts once our request is visible on the bus (drops stale acks after reset).
   assign ack_s    = imem_ack & imem_req_q;
   assign target_s = {redirect_pc[31:2], 2'b00};
   assign seq_pc_s = fetch_addr_q + 32'd4;

   // Next-state and next-output computation; redirect outranks every other event.
   always_comb begin
      state_d      = state_q;
      pc_d         = pc_q;
      fetch_addr_d = fetch_addr_q;
      id_instr_d   = id_instr_q;
      id_pc_d      = id_pc_q;
      id_pcplus4_d = id_pcplus4_q;
      case (state_q)
         S_FETCH: begin
            if (redirect_valid) begin
               pc_d = target_s;
               if (ack_s) begin
                  state_d      = S_FETCH;
                  fetch_addr_d = target_s;
               end else begin
                  state_d = S_DISCARD;
               end
            end else if (ack_s) begin
               id_instr_d   = imem_rdata;
               id_pc_d      = fetch_addr_q;
               id_pcplus4_d = seq_pc_s;
               pc_d         = seq_pc_s;
               state_d      = S_HOLD;
            end else begin
               state_d = S_FETCH;
            end
         end
         S_DISCARD: begin
            // With no ack pending after the drop, the newest target must be issued directly.
            if (redirect_valid) begin
               pc_d = target_s;
               if (ack_s) begin
                  state_d      = S_FETCH;
                  fetch_addr_d = target_s;
               end else begin
                  state_d = S_DISCARD;
               end
            end else if (ack_s) begin
               state_d      = S_FETCH;
               fetch_addr_d = pc_q;
            end else begin
               state_d = S_DISCARD;
            end
         end
         S_HOLD: begin
            if (redirect_valid) begin
               pc_d         = target_s;
               fetch_addr_d = target_s;
               state_d      = S_FETCH;
            end else if (id_ready) begin
               fetch_addr_d = pc_q;
               state_d      = S_FETCH;
            end else begin
               state_d = S_HOLD;
            end
         end
         default: begin
            state_d      = S_FETCH;
            fetch_addr_d = pc_q;
         end
      endcase
      imem_req_d = (state_d != S_HOLD);
      id_valid_d = (state_d == S_HOLD);
   end

   // State and registered outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= S_FETCH;
         pc_q         <= RESET_PC;
         fetch_addr_q <= RESET_PC;
         imem_req_q   <= 1'b0;
         id_valid_q   <= 1'b0;
         id_instr_q   <= NOP_INSTR;
         id_pc_q      <= 32'h0000_0000;
         id_pcplus4_q <= 32'h0000_0000;
      end else begin
         state_q      <= state_d;
         pc_q         <= pc_d;
         fetch_addr_q <= fetch_addr_d;
         imem_req_q   <= imem_req_d;
         id_valid_q   <= id_valid_d;
         id_instr_q   <= id_instr_d;
         id_pc_q      <= id_pc_d;
         id_pcplus4_q <= id_pcplus4_d;
      end
   end

   assign imem_req   = imem_req_q;
   assign imem_addr  = fetch_addr_q;
   assign id_valid   = id_valid_q;
   assign id_instr   = id_instr_q;
   assign id_pc      = id_pc_q;
   assign id_pcplus4 = id_pcplus4_q;
   assign Op         = id_instr_q[6:0];

endmodule
